// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Operand width used when the instantiating unit does not override it
    localparam int DIV_WIDTH_DEFAULT = 4;

    // Iteration counter width: enough bits to hold 0..WIDTH-1, never less than 1
    function automatic int div_cnt_w(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/sub_div_ctrl_if.sv
// Request/result bundle between the operation decoder and the divider.
// master: the decoder side; slave: the divider side.
interface sub_div_ctrl_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration built around a W-bit
// ripple-borrow subtractor. The trial value is {R, Q msb}; its top bit
// only decides whether a borrow out of the low W bits is a real negative.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit,
    output logic             o_neg
);
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_borrow;

    assign w_trial     = {i_rem, i_q_msb};
    assign w_borrow[0] = 1'b0;

    // Ripple-borrow subtractor: w_trial[WIDTH-1:0] - i_div
    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
        assign w_diff[i]       = w_trial[i] ^ i_div[i] ^ w_borrow[i];
        assign w_borrow[i + 1] = (~w_trial[i] & i_div[i]) |
                                 (~(w_trial[i] ^ i_div[i]) & w_borrow[i]);
    end

    // Negative only if the low-word borrow is not absorbed by the trial's top bit
    assign o_neg   = w_borrow[WIDTH] & ~w_trial[WIDTH];
    assign o_rem   = o_neg ? w_trial[WIDTH-1:0] : w_diff;
    assign o_q_bit = ~o_neg;
endmodule

// File: rtl/sub_div_ctrl.sv
// Sequential restoring-division controller: one div_step shared over WIDTH
// cycles yields an unsigned quotient and remainder.
// Optional feature macro: DIV_ZERO_CHECK_EN -- a zero divisor skips the
// iterations and reports div_by_zero for the single DONE cycle.
module sub_div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    sub_div_ctrl_if.slave bus
);
    localparam int CNT_W = div_cnt_w(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic             w_neg;
    logic             w_accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem   (r_r),
        .i_q_msb (r_q[WIDTH-1]),
        .i_div   (r_d),
        .o_rem   (w_rem_next),
        .o_q_bit (w_q_bit),
        .o_neg   (w_neg)
    );

    // A new request is taken only when no division is in flight
    assign w_accept = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);

`ifdef DIV_ZERO_CHECK_EN
    logic r_dbz;

    // Flag a zero divisor on the accepting edge; it lives exactly as long as DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbz <= 1'b0;
        end else begin
            r_dbz <= w_accept && (bus.divisor == '0);
        end
    end

    assign bus.div_by_zero = r_dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    // FSM, operand capture and one shift/subtract iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_r   <= w_rem_next;
                    r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        r_d   <= bus.divisor;
`ifdef DIV_ZERO_CHECK_EN
                        if (bus.divisor == '0) begin
                            r_q     <= '1;
                            r_r     <= bus.dividend;
                            r_state <= ST_DONE;
                        end else begin
                            r_q     <= bus.dividend;
                            r_r     <= '0;
                            r_state <= ST_RUN;
                        end
`else
                        r_q     <= bus.dividend;
                        r_r     <= '0;
                        r_state <= ST_RUN;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // w_neg is implied by the quotient bit; expose only what the datapath needs
    logic w_unused;
    assign w_unused = w_neg;

    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.quotient  = r_q;
    assign bus.remainder = r_r;
endmodule

// File: tb/tb_sub_div_ctrl.sv
// Directed bench for sub_div_ctrl at WIDTH=4: a vector table of single
// divisions plus hand-written multi-cycle sequences.
module tb_sub_div_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sub_div_ctrl_if #(.WIDTH(W)) bus ();

    sub_div_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           bsy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Wait (bounded) for done, counting edges since the accept edge and busy cycles
    task automatic wait_done(inout int edges, inout int bsy);
        while (!bus.done && edges < 40) begin
            if (bus.busy) bsy++;
            @(posedge clk); #1;
            edges++;
        end
        check("done_within_bound", int'(bus.done), 1);
    endtask

    initial begin
        int edges;
        int bsy;
        bit seen;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs.push_back('{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5, 4});
        vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5, 4});
        vecs.push_back('{4'd7,  4'd9,  4'd0,  4'd7, 1'b0, 5, 4});
        vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5, 4});
        vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5, 4});
        vecs.push_back('{4'd10, 4'd2,  4'd5,  4'd0, 1'b0, 5, 4});
`ifdef DIV_ZERO_CHECK_EN
        vecs.push_back('{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1, 0});
`else
        vecs.push_back('{4'd9,  4'd0,  4'd15, 4'd9, 1'b0, 5, 4});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_quot", int'(bus.quotient), 0);
        check("rst_rem",  int'(bus.remainder), 0);
        check("rst_dbz",  int'(bus.div_by_zero), 0);

        // Table-driven single divisions
        foreach (vecs[i]) begin
            bus.start    = 1'b1;
            bus.dividend = vecs[i].a;
            bus.divisor  = vecs[i].b;
            @(posedge clk); #1;
            bus.start = 1'b0;
            edges = 1;
            bsy   = 0;
            wait_done(edges, bsy);
            $display("vector %0d/%0d", vecs[i].a, vecs[i].b);
            check("vec_latency", edges, vecs[i].lat);
            check("vec_busy_cycles", bsy, vecs[i].bsy);
            check("vec_quot", int'(bus.quotient), int'(vecs[i].q));
            check("vec_rem",  int'(bus.remainder), int'(vecs[i].r));
            check("vec_dbz",  int'(bus.div_by_zero), int'(vecs[i].dbz));
            @(posedge clk); #1;
            check("vec_done_one_cycle", int'(bus.done), 0);
            check("vec_dbz_clears", int'(bus.div_by_zero), 0);
            check("vec_quot_held", int'(bus.quotient), int'(vecs[i].q));
            check("vec_rem_held",  int'(bus.remainder), int'(vecs[i].r));
        end

        // Start during busy is ignored: 12/5 runs, 6/2 pulsed in cycle 2
        bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 4'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 3;
        bsy   = 0;
        wait_done(edges, bsy);
        check("ign_latency", edges, 5);
        check("ign_quot", int'(bus.quotient), 2);
        check("ign_rem",  int'(bus.remainder), 2);
        @(posedge clk); #1;

        // Back-to-back: 14/4 then 8/3 requested during the DONE cycle
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 1;
        bsy   = 0;
        wait_done(edges, bsy);
        check("b2b_first_latency", edges, 5);
        check("b2b_first_quot", int'(bus.quotient), 3);
        check("b2b_first_rem",  int'(bus.remainder), 2);
        bus.start = 1'b1; bus.dividend = 4'd8; bus.divisor = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_busy_rises", int'(bus.busy), 1);
        check("b2b_done_falls", int'(bus.done), 0);
        edges = 1;
        bsy   = 0;
        wait_done(edges, bsy);
        check("b2b_second_latency", edges, 5);
        check("b2b_second_quot", int'(bus.quotient), 2);
        check("b2b_second_rem",  int'(bus.remainder), 2);
        @(posedge clk); #1;

        // Reset in the third RUN cycle aborts with no done
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before_rst", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_quot", int'(bus.quotient), 0);
        check("abort_rem",  int'(bus.remainder), 0);
        check("abort_dbz",  int'(bus.div_by_zero), 0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("abort_no_done", int'(seen), 0);

        // Reset together with start: reset wins
        rst = 1'b1;
        bus.start = 1'b1; bus.dividend = 4'd5; bus.divisor = 4'd1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", int'(bus.busy), 0);
        check("rst_start_quot", int'(bus.quotient), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sub_div_ctrl.md
# sub_div_ctrl

Sequential restoring-division controller for the calculator's divide function. It time-shares one W-bit ripple-borrow subtractor across W iterations to produce quotient and remainder. It sits beside the add/subtract/multiply units and is started by the calculator's operation decoder with a single-cycle start pulse.

## Interface

**Parameters**
- WIDTH, 4, operand width in bits; values from 2 to 16.

**Ports**
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request pulse; accepted only in IDLE or DONE.
- dividend  input  WIDTH  numerator; sampled on the accepting edge.
- divisor  input  WIDTH  denominator; sampled on the accepting edge.
- busy  output  1  high in RUN.
- done  output  1  high for exactly one cycle (state DONE); results valid.
- quotient  output  WIDTH  result; registered.
- remainder  output  WIDTH  result; registered.
- div_by_zero  output  1  high with done when the captured divisor was 0.

## Operation

- **Reset:** state=IDLE. busy, done and div_by_zero are 0. quotient, remainder and the iteration count are 0. A reset mid-RUN aborts the operation, and no done is produced.
- **States:**
  - IDLE → RUN on start. With DIV_ZERO_CHECK_EN and divisor==0, IDLE → DONE instead.
  - RUN → DONE after WIDTH iterations.
  - DONE → RUN/DONE on start (same rules as IDLE); otherwise DONE → IDLE.
- **Capture:** the accepting edge loads:
  - Q ← dividend
  - R ← 0
  - D ← divisor
  - count ← 0
- **Iteration** (one per cycle in RUN):
  - Form the trial value T = {R, Q[WIDTH-1]}, WIDTH+1 bits.
  - Subtract D from T[WIDTH-1:0] with borrow-in 0, giving diff and bout.
  - The trial is negative when bout=1 and T[WIDTH]=0.
  - If negative: R ← T[WIDTH-1:0] and Q ← {Q[WIDTH-2:0], 0} (restore).
  - Otherwise: R ← diff and Q ← {Q[WIDTH-2:0], 1}.
  - count increments; the last iteration runs at count == WIDTH-1.
- **Outputs:**
  - quotient=Q and remainder=R at all times.
  - Values are meaningful only while done=1. They hold unchanged from DONE until the next accepted start.
- **Ignored starts:** start in RUN is ignored, with no queuing and no error.
- **Arithmetic:** unsigned only. R never exceeds D-1 after a non-restoring step. The W-bit subtract is sufficient because T < 2·D ≤ 2^(WIDTH+1).

## Timing

- **Normal latency:** start accepted at edge k; iterations at edges k+1..k+WIDTH; done=1 in the cycle after edge k+WIDTH. Total: WIDTH+1 edges from request to results (5 for WIDTH=4).
- **busy:** 1 for exactly WIDTH cycles; 0 in DONE.
- **Back-to-back:** start asserted during the DONE cycle is accepted. done falls and busy rises at the next edge, so throughput is one result per WIDTH+1 cycles.
- **Zero-divisor fast path** (macro on): done and div_by_zero are 1 in the cycle after the accepting edge, with latency 1.
- **Simultaneous events:** rst together with start gives rst priority.

## Configuration

- **DIV_ZERO_CHECK_EN defined:**
  - A zero divisor bypasses RUN.
  - quotient = all ones, remainder = dividend, div_by_zero=1 for the DONE cycle. div_by_zero clears on leaving DONE.
- **Not defined:**
  - A zero divisor runs the full WIDTH iterations, which yields the same quotient and remainder values.
  - div_by_zero is tied to 0.

## Structure

- **Package `div_pkg`:**
  - State typedef (IDLE, RUN, DONE).
  - Default width constant (4).
  - Function returning the iteration counter width, $clog2(WIDTH) with a minimum of 1.
- **Sub-module `div_step`:** one combinational iteration. It wraps the team's W-bit ripple-borrow subtractor, takes R, Q msb and D, and produces next R, the quotient bit and the negative flag. sub_div_ctrl holds the FSM, registers and counter.

## Test plan

- **13/3, WIDTH=4:** start at edge 0 → busy for edges 1–4; done=1 in cycle 5; quotient=4, remainder=1, div_by_zero=0.
- **Boundary values:**
  - 15/1 → quotient=15, remainder=0.
  - 7/9 → quotient=0, remainder=7.
  - 15/15 → quotient=1, remainder=0.
- **9/0:**
  - Macro on → done in cycle 1, quotient=15, remainder=9, div_by_zero=1.
  - Macro off → done in cycle 5, quotient=15, remainder=9, div_by_zero=0.
- **Start during busy:** start 12/5, then pulse start with 6/2 in cycle 2 → second request ignored; result quotient=2, remainder=2.
- **Reset mid-run:** rst high in cycle 3 of RUN → next cycle state IDLE, all outputs 0, and no done pulse.
- **Back-to-back:** 14/4 with start held into the DONE cycle carrying 8/3 → quotient=3, remainder=2 valid at cycle 5; quotient=2, remainder=2 valid at cycle 10.
